pwm_peripheral: RTL

PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_prescaler.sv | 31 +++
 rtl/pwm_peripheral.sv | 80 ++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM peripheral.
// Used by pwm_prescaler and pwm_peripheral (PWM_DUTY_SHADOW_EN is handled in the top).
package pwm_pkg;

    localparam int PWM_WIDTH              = 8;
    localparam logic [PWM_WIDTH-1:0] DUTY_FULL = 8'hFF;
    localparam int CLK_DIV_DEFAULT        = 13;

    // Prescaler counter width for a given divide ratio; never narrower than 1 bit
    function automatic int presc_width(input int clk_div);
        return (clk_div > 1) ? $clog2(clk_div) : 1;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: counts 0..CLK_DIV-1 and flags tick_o on the last count.
// With CLK_DIV=1 the counter is pinned at 0 and tick_o is permanently high.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int CW = presc_width(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);

    // Next divide count: wrap to zero on the tick
    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end

    // Divide counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-output PWM peripheral: shared 8-bit PWM counter stepped by a prescaler
// tick, one shared duty value, per-output enable / PWM-mode select.
// Define PWM_DUTY_SHADOW_EN to latch the duty only at each period start.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    logic                 tick;
    logic                 wrap;
    logic                 pwm;
    logic [PWM_WIDTH-1:0] ctr_q, ctr_d;
    logic [PWM_WIDTH-1:0] duty_eff;
    logic [15:0]          en_out, en_pwm;
    logic [15:0]          out_q, out_d;
    logic                 ps_q;

    pwm_prescaler #(
        .CLK_DIV(CLK_DIV)
    ) u_prescaler (
        .clk_i  (clk),
        .rst_i  (rst),
        .tick_o (tick)
    );

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // The tick that rolls the counter 255 -> 0 marks a new period
    assign wrap = tick && (ctr_q == '1);

`ifdef PWM_DUTY_SHADOW_EN
    logic [PWM_WIDTH-1:0] duty_q;

    // Duty shadow: captured only on the period-start tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       duty_q <= '0;
        else if (wrap) duty_q <= pwm_duty_cycle;
    end

    assign duty_eff = duty_q;
`else
    assign duty_eff = pwm_duty_cycle;
`endif

    // Counter advance, PWM compare and per-output mux
    always_comb begin
        ctr_d = tick ? ctr_q + 1'b1 : ctr_q;
        pwm   = (duty_eff == DUTY_FULL) || (ctr_q < duty_eff);
        out_d = (en_out & ~en_pwm) | (en_out & en_pwm & {16{pwm}});
    end

    // PWM counter, registered outputs and period-start pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctr_q <= '0;
            out_q <= '0;
            ps_q  <= 1'b0;
        end else begin
            ctr_q <= ctr_d;
            out_q <= out_d;
            ps_q  <= wrap;
        end
    end

    assign out          = out_q;
    assign period_start = ps_q;

endmodule
